// File: rtl/gsim_bgen_if.sv
// Stream bundle for gsim_bgen: x words in, b words out in the solver's
// in_en/b_in style, plus frame status.
interface gsim_bgen_if #(
  parameter int XW = 32,
  parameter int BW = 16
);
  logic          x_valid;
  logic [XW-1:0] x_in;
  logic          x_ready;
  logic          b_en;
  logic [BW-1:0] b_out;
  logic          done;
  logic          sat;

  modport master (
    output x_valid, x_in,
    input  x_ready, b_en, b_out, done, sat
  );

  modport slave (
    input  x_valid, x_in,
    output x_ready, b_en, b_out, done, sat
  );
endinterface

// File: rtl/gsim_bgen.sv
// Computes b = A*x for the Gauss-Seidel solver's banded matrix (20/-13/6/-1)
// from a 16-word Q16.16 x frame and streams b as rounded, saturated integers.
module gsim_bgen #(
  parameter int N    = 16,
  parameter int XW   = 32,
  parameter int BW   = 16,
  parameter int FRAC = 16
) (
  input logic        clk,
  input logic        rst_in,
  gsim_bgen_if.slave bus
);
  localparam int AW = 39;
  localparam int IW = $clog2(N);
  localparam logic signed [AW-1:0] B_MAX = {{(AW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [AW-1:0] B_MIN = {{(AW-BW+1){1'b1}}, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [IW-1:0]        load_idx_r;
  logic [IW-1:0]        send_idx_r;
  logic [XW-1:0]        buf_r [N];
  logic                 x_ready_r;
  logic                 b_en_r;
  logic [BW-1:0]        b_out_r;
  logic                 done_r;
  logic                 sat_r;
  logic                 accept_s;
  int                   pos_s;
  logic signed [AW-1:0] win_s [7];
  logic signed [AW-1:0] c0_s;
  logic signed [AW-1:0] p1_s;
  logic signed [AW-1:0] p2_s;
  logic signed [AW-1:0] p3_s;
  logic signed [AW-1:0] acc_s;
  logic signed [AW-1:0] rnd_s;
  logic [BW-1:0]        b_sat_s;
  logic                 clamp_s;

  function automatic logic signed [AW-1:0] sext(input logic [XW-1:0] v);
    return {{(AW-XW){v[XW-1]}}, v};
  endfunction

  // Next-state logic and the load handshake qualifier.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_LOAD: begin
        accept_s = bus.x_valid & x_ready_r;
        if (accept_s && (load_idx_r == IW'(N-1))) state_nx_s = ST_SEND;
        else                                      state_nx_s = ST_LOAD;
      end
      ST_SEND: begin
        if (send_idx_r == IW'(N-1)) state_nx_s = ST_DONE;
        else                        state_nx_s = ST_SEND;
      end
      ST_DONE: state_nx_s = ST_LOAD;
      default: state_nx_s = ST_LOAD;
    endcase
  end

  // Seven-tap window around the element being sent; taps outside the vector read as zero.
  always_comb begin
    pos_s = 0;
    for (int d = 0; d < 7; d++) begin
      pos_s = int'(send_idx_r) + d - 3;
      if ((pos_s >= 0) && (pos_s < N)) win_s[d] = sext(buf_r[pos_s[IW-1:0]]);
      else                             win_s[d] = '0;
    end
  end

  // Band sum by shift-add, round half up, then clamp to the b range.
  always_comb begin
    c0_s    = win_s[3];
    p1_s    = win_s[2] + win_s[4];
    p2_s    = win_s[1] + win_s[5];
    p3_s    = win_s[0] + win_s[6];
    acc_s   = (c0_s <<< 4) + (c0_s <<< 2)
            - ((p1_s <<< 3) + (p1_s <<< 2) + p1_s)
            + ((p2_s <<< 2) + (p2_s <<< 1))
            - p3_s;
    rnd_s   = (acc_s + (39'sd1 <<< (FRAC-1))) >>> FRAC;
    clamp_s = 1'b0;
    b_sat_s = rnd_s[BW-1:0];
    if (rnd_s > B_MAX) begin
      clamp_s = 1'b1;
      b_sat_s = {1'b0, {(BW-1){1'b1}}};
    end else if (rnd_s < B_MIN) begin
      clamp_s = 1'b1;
      b_sat_s = {1'b1, {(BW-1){1'b0}}};
    end else begin
      clamp_s = 1'b0;
      b_sat_s = rnd_s[BW-1:0];
    end
  end

  // State, indices and registered outputs.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_r    <= ST_LOAD;
      load_idx_r <= '0;
      send_idx_r <= '0;
      x_ready_r  <= 1'b0;
      b_en_r     <= 1'b0;
      b_out_r    <= '0;
      done_r     <= 1'b0;
      sat_r      <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      x_ready_r <= (state_nx_s == ST_LOAD);
      b_en_r    <= (state_r == ST_SEND);
      done_r    <= (state_r == ST_DONE);
      if (accept_s) load_idx_r <= load_idx_r + IW'(1);
      if (state_r == ST_SEND) begin
        send_idx_r <= send_idx_r + IW'(1);
        b_out_r    <= b_sat_s;
      end else begin
        send_idx_r <= '0;
      end
      // sat is sticky across the frame and only drops when the next frame starts loading.
      if ((state_r == ST_SEND) && clamp_s)          sat_r <= 1'b1;
      else if (accept_s && (load_idx_r == IW'(0)))  sat_r <= 1'b0;
    end
  end

  // x buffer; only written by words accepted while loading.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) buf_r[i] <= '0;
    end else if (accept_s) begin
      buf_r[load_idx_r] <= bus.x_in;
    end
  end

  assign bus.x_ready = x_ready_r;
  assign bus.b_en    = b_en_r;
  assign bus.b_out   = b_out_r;
  assign bus.done    = done_r;
  assign bus.sat     = sat_r;
endmodule

// File: tb/tb_gsim_bgen.sv
// Randomised frame bench for gsim_bgen: a plain-arithmetic b = A*x model feeds
// an expectation queue that a single negedge compare process checks.
module tb_gsim_bgen;
  typedef logic [31:0] xvec_t [16];
  typedef int ivec_t [16];

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_b_q[$];
  int exp_s_q[$];
  int acc_q[$];
  int bcnt = 0;
  bit done_pend = 1'b0;
  int sat_acc = 0;

  gsim_bgen_if #(.XW(32), .BW(16)) bus();

  gsim_bgen dut (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // b_k = sum_j A[k][j] * x_j with A banded by |k-j|; round half up; clamp.
  function automatic void model(input xvec_t x, output ivec_t b, output ivec_t s);
    int c[4] = '{20, -13, 6, -1};
    longint sum, r, xv;
    int d;
    for (int k = 0; k < 16; k++) begin
      sum = 0;
      for (int j = 0; j < 16; j++) begin
        d = (j > k) ? j - k : k - j;
        xv = longint'($signed(x[j]));
        if (d <= 3) sum += longint'(c[d]) * xv;
      end
      r = (sum + 64'sd32768) >>> 16;
      s[k] = (r > 32767 || r < -32768) ? 1 : 0;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      b[k] = int'(r);
    end
  endfunction

  // Output checker: reset values, b stream contents/latency/contiguity, done and sat.
  initial begin
    int eb, es;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        chk("rst_x_ready", bus.x_ready, 0);
        chk("rst_b_en", bus.b_en, 0);
        chk("rst_b_out", bus.b_out, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sat", bus.sat, 0);
        exp_b_q.delete(); exp_s_q.delete(); acc_q.delete();
        bcnt = 0; done_pend = 1'b0; sat_acc = 0;
      end else begin
        if (done_pend) begin
          chk("done_pulse", bus.done, 1);
          chk("b_en_after_b15", bus.b_en, 0);
          done_pend = 1'b0;
        end else begin
          chk("done_idle", bus.done, 0);
        end
        if (bus.b_en) begin
          if (exp_b_q.size() == 0) begin
            chk("unexpected_b_en", 1, 0);
          end else begin
            if (bcnt == 0) begin
              sat_acc = 0;
              if (acc_q.size() > 0) chk("latency_cycle", cyc, acc_q.pop_front() + 1);
            end
            eb = exp_b_q.pop_front();
            es = exp_s_q.pop_front();
            sat_acc = sat_acc | es;
            chk($sformatf("b%0d", bcnt), $signed(bus.b_out), eb);
            chk("sat_in_frame", bus.sat, sat_acc);
            chk("x_ready_in_send", bus.x_ready, 0);
            bcnt++;
            if (bcnt == 16) begin
              bcnt = 0;
              done_pend = 1'b1;
            end
          end
        end else if (bcnt != 0) begin
          chk("b_en_gap", 0, 1);
          for (int i = bcnt; i < 16; i++) begin
            if (exp_b_q.size() > 0) begin
              eb = exp_b_q.pop_front();
              es = exp_s_q.pop_front();
            end
          end
          bcnt = 0;
        end
      end
    end
  end

  task automatic send_frame(input xvec_t x, input int gap_pct, input bit hold);
    ivec_t b, s;
    bit took;
    int tmo;
    model(x, b, s);
    for (int k = 0; k < 16; k++) begin
      exp_b_q.push_back(b[k]);
      exp_s_q.push_back(s[k]);
    end
    for (int i = 0; i < 16; i++) begin
      took = 1'b0;
      tmo = 0;
      while (!took) begin
        @(negedge clk);
        if (!bus.x_ready) begin
          bus.x_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
          bus.x_in    = $urandom;
        end else if ($urandom_range(0, 99) < gap_pct) begin
          bus.x_valid = 1'b0;
          bus.x_in    = $urandom;
        end else begin
          bus.x_valid = 1'b1;
          bus.x_in    = x[i];
          took = 1'b1;
          if (i == 15) acc_q.push_back(cyc + 1);
        end
        tmo++;
        if (!took && tmo > 200) begin
          chk("x_ready_timeout", 0, 1);
          bus.x_valid = 1'b0;
          return;
        end
      end
      if (i == 0) begin
        @(posedge clk);
        #1;
        chk("sat_cleared_on_x0", bus.sat, 0);
      end
    end
    if (!hold) begin
      @(negedge clk);
      bus.x_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_b_q.size() == 0 && bcnt == 0 && !done_pend) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    xvec_t xu, xi, xr, xs, x0, xa;
    ivec_t b, s;
    int n;
    logic [31:0] v;
    bus.x_valid = 1'b0;
    bus.x_in    = '0;
    for (int i = 0; i < 16; i++) begin
      xu[i] = 32'h0001_0000;
      xi[i] = (i == 5) ? 32'h0001_0000 : 32'h0;
      xr[i] = (i == 0) ? 32'h0000_0CCD : 32'h0;
      xs[i] = 32'h7FFF_FFFF;
      x0[i] = (i == 0) ? 32'h0001_0000 : 32'h0;
    end

    model(xu, b, s);
    chk("model_uni_b0", b[0], 12);  chk("model_uni_b1", b[1], -1);
    chk("model_uni_b2", b[2], 5);   chk("model_uni_b7", b[7], 4);
    chk("model_uni_b14", b[14], -1);
    model(xi, b, s);
    chk("model_imp_b4", b[4], -13); chk("model_imp_b5", b[5], 20);
    chk("model_imp_b8", b[8], -1);  chk("model_imp_b9", b[9], 0);
    model(xr, b, s);
    chk("model_rnd_b0", b[0], 1);   chk("model_rnd_b1", b[1], -1);
    chk("model_rnd_b2", b[2], 0);   chk("model_rnd_b3", b[3], 0);
    model(xs, b, s);
    chk("model_sat_b0", b[0], 32767); chk("model_sat_b1", b[1], -32768);
    chk("model_sat_b14", b[14], -32768); chk("model_sat_s0", s[0], 1);
    model(x0, b, s);
    chk("model_x0_b0", b[0], 20);   chk("model_x0_b3", b[3], -1);

    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst_in = 1'b0;
    @(posedge clk); #1 chk("x_ready_after_reset", bus.x_ready, 1);

    send_frame(xu, 0, 1'b0); wait_idle();
    send_frame(xi, 0, 1'b0); wait_idle();
    send_frame(xr, 0, 1'b0); wait_idle();
    send_frame(xs, 0, 1'b0); wait_idle();
    send_frame(xu, 0, 1'b0); wait_idle();

    // Gapped load, garbage held valid through SEND, then a back-to-back frame.
    for (int i = 0; i < 16; i++) xa[i] = $urandom;
    send_frame(xa, 40, 1'b1);
    send_frame(x0, 0, 1'b1);
    @(negedge clk); bus.x_valid = 1'b0;
    wait_idle();

    // Abort a saturating frame right after b6 is on the bus.
    send_frame(xs, 0, 1'b0);
    n = 0;
    while (bcnt != 7 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("wait_b6_timeout", 0, 1);
    @(posedge clk); #2 rst_in = 1'b1;
    #1;
    chk("midreset_b_en", bus.b_en, 0);
    chk("midreset_done", bus.done, 0);
    chk("midreset_sat", bus.sat, 0);
    repeat (2) @(posedge clk);
    #3 rst_in = 1'b0;
    @(posedge clk); #1 chk("x_ready_after_midreset", bus.x_ready, 1);
    send_frame(xu, 0, 1'b0); wait_idle();

    for (int f = 0; f < 9; f++) begin
      for (int i = 0; i < 16; i++) begin
        v = $urandom;
        case (f % 3)
          0:       xa[i] = {{10{v[21]}}, v[21:0]};
          1:       xa[i] = v;
          default: xa[i] = {{6{v[25]}}, v[25:0]};
        endcase
      end
      send_frame(xa, $urandom_range(0, 50), 1'(f % 2));
    end
    @(negedge clk); bus.x_valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/gsim_bgen.md
Name: gsim_bgen

Overview:
- Forward-direction companion to the Gauss-Seidel solver: takes a 16-element solution vector x (signed Q16.16) and computes the right-hand side b = A·x.
- A is the solver's fixed banded matrix: diagonal 20, ±1 band −13, ±2 band 6, ±3 band −1; out-of-range neighbours count as 0.
- Streams b as 16-bit integers using the solver's input protocol (in_en/b_in style), so it can drive the solver directly or regenerate stimulus/check results in closed loop.

Parameters:
- N, 16, vector length; fixed to 16, other values unsupported.
- XW, 32, x word width, signed Q16.16.
- BW, 16, b word width, signed integer.
- FRAC, 16, fractional bits of x removed on output.

Ports:
- clk  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- x_valid  input  1  x_in carries a word this cycle.
- x_in  input  32  x element, signed Q16.16, order x0..x15.
- x_ready  output  1  block accepts x; word transfers when x_valid & x_ready at the rising edge.
- b_en  output  1  b_out valid; high for exactly 16 consecutive cycles per frame.
- b_out  output  16  b element, signed, order b0..b15.
- done  output  1  one-cycle pulse after the last b is sent.
- sat  output  1  sticky: some b in the current frame saturated; cleared when the next frame's first x is accepted.

Behaviour:
- Reset (async) values: x_ready=0 while rst_in is high; x_ready=1 on the first clock after release. b_en=0, b_out=0, done=0, sat=0. Load index=0, send index=0, buffer cleared to 0, state=LOAD.
- States:
  - LOAD: x_ready=1; each accepted word is written to buf[idx] and idx increments. Gaps in x_valid are allowed. Accepting the word at idx=15 moves to SEND; x_ready drops to 0 in the following cycle.
  - SEND: one-stage pipeline. The sum for index k is computed combinationally and registered; the register drives b_out/b_en. The first b_en-high cycle is the 2nd cycle after the acceptance edge of x15 (latency 2). b0..b15 follow on consecutive cycles with no gaps.
  - DONE: one cycle with done=1, b_en=0. Then LOAD with idx=0 and x_ready=1, so back-to-back frames are possible.
- x_valid outside LOAD is ignored; the buffer is not modified.
- Arithmetic:
  - s_k = 20·x_k − 13·(x_{k−1}+x_{k+1}) + 6·(x_{k−2}+x_{k+2}) − (x_{k−3}+x_{k+3}).
  - Terms with index <0 or >15 are 0.
  - Use a 39-bit signed accumulator; no intermediate overflow is possible.
  - Rounding is round-half-up: r = (s_k + 2^15) >>> 16, arithmetic shift.
  - Saturation: r clamped to [−32768, 32767]; any clamp sets sat.
- Multiplies are shift-add only (20=16+4, 13=8+4+1, 6=4+2); no multiplier instances.
- b_out holds its last value when b_en=0; only b_en qualifies it.
- Reset mid-frame (LOAD or SEND) aborts immediately. Outputs take reset values asynchronously; no partial b stream resumes after release.
- sat and done are never asserted during reset.

Test Plan:
- Uniform vector: all x=0x00010000 (1.0) -> b = 12, −1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, −1, 12. b_en high exactly 16 cycles starting 2 cycles after x15 is accepted; done 1 cycle after b15; sat=0.
- Impulse: x5=0x00010000, others 0 -> b2=−1, b3=6, b4=−13, b5=20, b6=−13, b7=6, b8=−1, all other b=0.
- Rounding: x0=0x00000CCD, others 0 -> b0=1 (65540/65536), b1=−1 (−42601 rounds to −1), b2=0 (19662), b3=0 (−3277), rest 0.
- Saturation: all x=0x7FFFFFFF -> b0=32767, b1=−32768, b2..b13=32767, b14=−32768, b15=32767; sat=1 after the first b. Next frame's first accepted x clears sat.
- Handshake: x_valid toggled with random gaps during LOAD, and held high during SEND with garbage data -> only the 16 LOAD words are used, x_ready=0 throughout SEND/DONE. A back-to-back second frame (impulse x0=1.0) yields b0=20, b1=−13, b2=6, b3=−1, rest 0.
- Reset mid-SEND: assert rst_in after b6 -> b_en, done and sat are 0 in the same cycle. After release x_ready=1, and a new uniform frame reproduces scenario 1 exactly.
